// File: rtl/cpu_pkg.sv
// Shared encodings for the memory stage: load-op codes and the load-wait FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Load type as presented by execute on es_load_op
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } load_op_e;

  // IDLE: nothing outstanding (empty, or a non-load held)
  // WAIT: load held, SRAM data not yet returned
  // DONE: load held, SRAM data captured in the local buffer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks byte/half by address and sign- or zero-extends it.
// Latency: combinational. Backpressure: none.
// Sub-word selection only exists when MS_SUBWORD_LOAD_EN is defined; otherwise data passes unchanged.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic [2:0]        load_op_i,
  output logic [DATA_W-1:0] result_o
);

`ifdef MS_SUBWORD_LOAD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by low address bits, then extend according to the load type
  always_comb begin
    byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (load_op_i)
      LD_B:    result_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   result_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    result_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   result_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end
`else
  // Word-only build: address offset and load type carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{addr_i, load_op_i};
  assign result_o  = rdata_i;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for its load data, aligns it and forwards to writeback.
// Latency: 1 cycle for non-loads; loads leave the cycle data_sram_data_ok arrives (bypass) or later if buffered.
// Backpressure: ms_allowin drops while holding an unfinished or unaccepted instruction. Optional: MS_SUBWORD_LOAD_EN.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ws_allowin,
  output logic              ms_allowin,
  input  logic              es_to_ms_valid,
  input  logic [PC_W-1:0]   es_pc,
  input  logic              es_rf_we,
  input  logic [4:0]        es_rf_waddr,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_load_op,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              ms_to_ws_valid,
  output logic [PC_W-1:0]   ms_pc,
  output logic              ms_rf_we,
  output logic [4:0]        ms_rf_waddr,
  output logic [DATA_W-1:0] ms_rf_wdata,
  output logic              ms_load_pending
);

  logic              ms_valid_q;
  ms_state_e         state_q;
  logic [DATA_W-1:0] data_buf_q;

  logic [PC_W-1:0]   pc_q;
  logic              rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [DATA_W-1:0] alu_result_q;
  logic              res_from_mem_q;
  logic [2:0]        load_op_q;

  logic              ms_ready_go;
  logic              accept;
  logic [DATA_W-1:0] load_raw;
  logic [DATA_W-1:0] load_aligned;

  // A load is ready once its data is buffered or arriving right now
  assign ms_ready_go = !res_from_mem_q || (state_q == DONE) ||
                       ((state_q == WAIT) && data_sram_data_ok);
  assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign accept      = es_to_ms_valid && ms_allowin;

  // Valid bit advances whenever the stage can take a new slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_to_ms_valid;
    end
  end

  // Payload capture only on an actual handshake with execute
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q           <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      res_from_mem_q <= 1'b0;
      load_op_q      <= '0;
    end else if (accept) begin
      pc_q           <= es_pc;
      rf_we_q        <= es_rf_we;
      rf_waddr_q     <= es_rf_waddr;
      alu_result_q   <= es_alu_result;
      res_from_mem_q <= es_res_from_mem;
      load_op_q      <= es_load_op;
    end
  end

  // Load-wait FSM plus data buffer; responses outside WAIT are dropped
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      data_buf_q <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (data_sram_data_ok) begin
            data_buf_q <= data_sram_rdata;
            if (ws_allowin) begin
              // Data bypassed to writeback this cycle; slot refills immediately
              state_q <= (accept && es_res_from_mem) ? WAIT : IDLE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (ws_allowin) begin
            state_q <= (accept && es_res_from_mem) ? WAIT : IDLE;
          end
        end
        default: begin
          if (ms_allowin) begin
            state_q <= (accept && es_res_from_mem) ? WAIT : IDLE;
          end
        end
      endcase
    end
  end

  // Buffered data once captured, otherwise the live SRAM return
  assign load_raw = (state_q == DONE) ? data_buf_q : data_sram_rdata;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata_i   (load_raw),
    .addr_i    (alu_result_q[1:0]),
    .load_op_i (load_op_q),
    .result_o  (load_aligned)
  );

  assign ms_to_ws_valid  = ms_valid_q && ms_ready_go;
  assign ms_pc           = pc_q;
  assign ms_rf_we        = ms_valid_q && rf_we_q;
  assign ms_rf_waddr     = rf_waddr_q;
  assign ms_rf_wdata     = res_from_mem_q ? load_aligned : alu_result_q;
  assign ms_load_pending = ms_valid_q && res_from_mem_q && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a randomized run against a transaction model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected values come from constants or from the model below, never from the DUT.
module tb_mem_stage;

`ifdef MS_SUBWORD_LOAD_EN
  localparam bit SUBWORD_EN = 1'b1;
`else
  localparam bit SUBWORD_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic [2:0]  es_load_op;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_load_pending;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.DATA_W(32), .PC_W(32)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_pc             (es_pc),
    .es_rf_we          (es_rf_we),
    .es_rf_waddr       (es_rf_waddr),
    .es_alu_result     (es_alu_result),
    .es_res_from_mem   (es_res_from_mem),
    .es_load_op        (es_load_op),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_load_pending   (ms_load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load result computed arithmetically from the load-type rules
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] addr,
                                           input logic [2:0] op);
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] sub;
    b = (rdata >> (32'(addr) * 8)) & 32'hFF;
    h = (rdata >> (32'(addr[1]) * 16)) & 32'hFFFF;
    case (op)
      3'b001:  sub = (b >= 32'd128) ? b - 32'd256 : b;
      3'b101:  sub = b;
      3'b010:  sub = (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b110:  sub = h;
      default: sub = rdata;
    endcase
    return SUBWORD_EN ? sub : rdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_pc             = 32'h0;
    es_rf_we          = 1'b0;
    es_rf_waddr       = 5'd0;
    es_alu_result     = 32'h0;
    es_res_from_mem   = 1'b0;
    es_load_op        = 3'b000;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
  endtask

  task automatic present_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] wa);
    es_to_ms_valid  = 1'b1;
    es_pc           = 32'h1C00_0100;
    es_rf_we        = 1'b1;
    es_rf_waddr     = wa;
    es_alu_result   = addr;
    es_res_from_mem = 1'b1;
    es_load_op      = op;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if ({ms_allowin, ms_to_ws_valid, ms_rf_we, ms_load_pending, ms_rf_waddr} !== 9'b1_0_0_0_00000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want %b",
               {ms_allowin, ms_to_ws_valid, ms_rf_we, ms_load_pending, ms_rf_waddr}, 9'b100000000);
    end
    n_cmp++;
    if ({ms_pc, ms_rf_wdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got pc %h wdata %h want 0 0", ms_pc, ms_rf_wdata);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    es_to_ms_valid  = 1'b1;
    es_pc           = 32'h1C00_0010;
    es_rf_we        = 1'b1;
    es_rf_waddr     = 5'd5;
    es_alu_result   = 32'h1234_5678;
    es_res_from_mem = 1'b0;
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({ms_to_ws_valid, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_pc} !==
        {1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0010}) begin
      n_err++;
      $display("FAIL alu_pass: got v%b we%b wa%0d wd %h pc %h want v1 we1 wa5 wd 12345678 pc 1c000010",
               ms_to_ws_valid, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_pc);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({ms_to_ws_valid, ms_rf_we} !== 2'b00) begin
      n_err++;
      $display("FAIL alu_one_cycle: got v%b we%b want v0 we0", ms_to_ws_valid, ms_rf_we);
    end
    tick();
  endtask

  task automatic test_load_w();
    present_load(32'h0000_1000, 3'b000, 5'd7);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ms_load_pending, ms_to_ws_valid, ms_allowin} !== 3'b100) begin
        n_err++;
        $display("FAIL ldw_pending[%0d]: got pend/v/allowin %b want 100", i,
                 {ms_load_pending, ms_to_ws_valid, ms_allowin});
      end
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({ms_load_pending, ms_to_ws_valid, ms_rf_wdata, ms_rf_waddr} !== {1'b0, 1'b1, 32'hDEAD_BEEF, 5'd7}) begin
      n_err++;
      $display("FAIL ldw_bypass: got pend%b v%b wd %h wa%0d want pend0 v1 wd deadbeef wa7",
               ms_load_pending, ms_to_ws_valid, ms_rf_wdata, ms_rf_waddr);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ldw_after: got v%b want v0", ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_subword();
    logic [31:0] addrs [2];
    logic [2:0]  ops   [2];
    logic [31:0] wants [2];
    addrs[0] = 32'h0000_2003; ops[0] = 3'b001; wants[0] = SUBWORD_EN ? 32'hFFFF_FF80 : 32'h80FF_0000;
    addrs[1] = 32'h0000_2002; ops[1] = 3'b110; wants[1] = SUBWORD_EN ? 32'h0000_80FF : 32'h80FF_0000;
    for (int i = 0; i < 2; i++) begin
      present_load(addrs[i], ops[i], 5'd9);
      tick();
      idle_inputs();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h80FF_0000;
      @(negedge clk);
      n_cmp++;
      if ({ms_to_ws_valid, ms_rf_wdata} !== {1'b1, wants[i]}) begin
        n_err++;
        $display("FAIL subword[%0d]: got v%b wd %h want v1 wd %h", i, ms_to_ws_valid, ms_rf_wdata, wants[i]);
      end
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_hold();
    present_load(32'h0000_3000, 3'b000, 5'd11);
    tick();
    idle_inputs();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hA5A5_A5A5;
    @(negedge clk);
    n_cmp++;
    if ({ms_to_ws_valid, ms_allowin, ms_rf_wdata} !== {1'b1, 1'b0, 32'hA5A5_A5A5}) begin
      n_err++;
      $display("FAIL hold_arrive: got v%b allowin%b wd %h want v1 allowin0 wd a5a5a5a5",
               ms_to_ws_valid, ms_allowin, ms_rf_wdata);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      // A new instruction waits upstream; a stray response in the second cycle must be ignored
      present_load(32'h0000_4000, 3'b000, 5'd12);
      ws_allowin        = 1'b0;
      data_sram_data_ok = (i == 1);
      data_sram_rdata   = 32'h0BAD_F00D;
      @(negedge clk);
      n_cmp++;
      if ({ms_to_ws_valid, ms_allowin, ms_load_pending, ms_rf_wdata, ms_rf_waddr} !==
          {1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 5'd11}) begin
        n_err++;
        $display("FAIL hold_stall[%0d]: got v%b allowin%b pend%b wd %h wa%0d want v1 allowin0 pend0 wd a5a5a5a5 wa11",
                 i, ms_to_ws_valid, ms_allowin, ms_load_pending, ms_rf_wdata, ms_rf_waddr);
      end
      tick();
    end
    idle_inputs();
    data_sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    n_cmp++;
    if ({ms_to_ws_valid, ms_allowin, ms_rf_wdata} !== {1'b1, 1'b1, 32'hA5A5_A5A5}) begin
      n_err++;
      $display("FAIL hold_release: got v%b allowin%b wd %h want v1 allowin1 wd a5a5a5a5",
               ms_to_ws_valid, ms_allowin, ms_rf_wdata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_drained: got v%b want v0", ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [6];
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    present_load(32'h0000_5000, 3'b000, 5'd0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      idle_inputs();
      if (k < 6) present_load(32'h0000_5000 + 32'(k) * 4, 3'b000, 5'(k));
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = d[k-1];
      @(negedge clk);
      n_cmp++;
      if ({ms_to_ws_valid, ms_allowin, ms_rf_wdata, ms_rf_waddr} !== {1'b1, 1'b1, d[k-1], 5'(k-1)}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got v%b allowin%b wd %h wa%0d want v1 allowin1 wd %h wa%0d",
                 k, ms_to_ws_valid, ms_allowin, ms_rf_wdata, ms_rf_waddr, d[k-1], k-1);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (ms_to_ws_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: got v%b want v0", ms_to_ws_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    present_load(32'h0000_6000, 3'b000, 5'd3);
    tick();
    idle_inputs();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({ms_to_ws_valid, ms_load_pending, ms_allowin} !== 3'b001) begin
      n_err++;
      $display("FAIL rst_async: got v/pend/allowin %b want 001", {ms_to_ws_valid, ms_load_pending, ms_allowin});
    end
    tick();
    resetn = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    @(negedge clk);
    n_cmp++;
    if ({ms_to_ws_valid, ms_load_pending, ms_allowin} !== 3'b001) begin
      n_err++;
      $display("FAIL rst_late_ok: got v/pend/allowin %b want 001", {ms_to_ws_valid, ms_load_pending, ms_allowin});
    end
    tick();
    // A following ALU op must flow straight through, not be mistaken for buffered load data
    idle_inputs();
    es_to_ms_valid = 1'b1;
    es_rf_we       = 1'b1;
    es_rf_waddr    = 5'd4;
    es_alu_result  = 32'hCAFE_0001;
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({ms_to_ws_valid, ms_rf_wdata} !== {1'b1, 32'hCAFE_0001}) begin
      n_err++;
      $display("FAIL rst_recover: got v%b wd %h want v1 wd cafe0001", ms_to_ws_valid, ms_rf_wdata);
    end
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  op_tbl [5];
    // Model of the single held instruction
    bit          m_valid   = 1'b0;
    bit          m_load    = 1'b0;
    bit          m_arrived = 1'b0;
    int          m_delay   = 0;
    logic [31:0] m_rdata   = '0;
    logic [31:0] m_pc      = '0;
    bit          m_we      = 1'b0;
    logic [4:0]  m_waddr   = '0;
    logic [31:0] m_wdata   = '0;
    bit          ready;
    bit          e_valid;
    bit          e_allowin;
    bit          e_pend;
    logic [31:0] n_rdata;
    int          n_delay;
    op_tbl[0] = 3'b000; op_tbl[1] = 3'b001; op_tbl[2] = 3'b010; op_tbl[3] = 3'b101; op_tbl[4] = 3'b110;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ws_allowin      = ($urandom_range(3) != 0);
      es_to_ms_valid  = ($urandom_range(2) != 0);
      es_pc           = $urandom;
      es_rf_we        = 1'($urandom);
      es_rf_waddr     = 5'($urandom);
      es_alu_result   = $urandom;
      es_res_from_mem = 1'($urandom);
      es_load_op      = op_tbl[$urandom_range(4)];
      n_rdata         = $urandom;
      n_delay         = $urandom_range(3);
      if (m_valid && m_load && !m_arrived) begin
        data_sram_data_ok = (m_delay == 0);
        data_sram_rdata   = (m_delay == 0) ? m_rdata : $urandom;
      end else begin
        data_sram_data_ok = ($urandom_range(5) == 0);
        data_sram_rdata   = $urandom;
      end
      ready     = !m_load || m_arrived || data_sram_data_ok;
      e_valid   = m_valid && ready;
      e_allowin = !m_valid || (ready && ws_allowin);
      e_pend    = m_valid && m_load && !ready;
      @(negedge clk);
      n_cmp++;
      if ({ms_to_ws_valid, ms_allowin, ms_load_pending} !== {e_valid, e_allowin, e_pend}) begin
        n_err++;
        $display("FAIL rnd_hs[%0d]: got v/allowin/pend %b want %b", cyc,
                 {ms_to_ws_valid, ms_allowin, ms_load_pending}, {e_valid, e_allowin, e_pend});
      end
      if (e_valid) begin
        n_cmp++;
        if ({ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata} !== {m_pc, m_we, m_waddr, m_wdata}) begin
          n_err++;
          $display("FAIL rnd_wb[%0d]: got pc %h we%b wa%0d wd %h want pc %h we%b wa%0d wd %h", cyc,
                   ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, m_pc, m_we, m_waddr, m_wdata);
        end
      end
      if (m_valid && m_load && !m_arrived) begin
        if (data_sram_data_ok) m_arrived = 1'b1;
        else m_delay--;
      end
      if (e_allowin) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_load    = es_res_from_mem;
          m_arrived = 1'b0;
          m_delay   = n_delay;
          m_rdata   = n_rdata;
          m_pc      = es_pc;
          m_we      = es_rf_we;
          m_waddr   = es_rf_waddr;
          m_wdata   = es_res_from_mem ? ref_load(n_rdata, es_alu_result[1:0], es_load_op) : es_alu_result;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_w();
    test_subword();
    test_hold();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
